// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared types and helpers for the HLS deadlock report controller.
// Contents: report FSM state enum, default timestamp width, clog2 with minimum 1.
// Optional feature macro used by importers: HLS_DEADLOCK_TS_EN.
package hls_deadlock_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int TS_W_DEF = 32;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// hls_deadlock_persist_cnt: per-monitor persistence counter that confirms one deadlock per blocking episode.
// Ports: i_clk, i_rst_n (async active-low), i_block (monitor block flag),
//   i_ack (report handshake clears pending), i_clear (sync clear, highest priority),
//   o_pending (confirmed deadlock awaiting report), o_set (pending is being set this cycle).
module hls_deadlock_persist_cnt #(
  parameter int THRESH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_block,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_pending,
  output logic o_set
);
  localparam int CNT_W = $clog2(THRESH + 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_armed;
  logic w_set;
  // armed drops once an episode is confirmed so a held block reports only once
  assign w_set = i_block && r_armed && (r_cnt == CNT_W'(THRESH - 1));
  assign o_set = w_set && !i_clear;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_armed <= 1'b1;
      o_pending <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_armed <= 1'b1;
      o_pending <= 1'b0;
    end else begin
      r_cnt <= !i_block ? '0 : (r_cnt < CNT_W'(THRESH)) ? r_cnt + 1'b1 : r_cnt;
      r_armed <= !i_block || (r_armed && !w_set);
      // a new confirmation beats a simultaneous handshake clear
      o_pending <= w_set || (o_pending && !i_ack);
    end
  end
endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// hls_deadlock_report_ctrl: confirms persistent HLS monitor blocks and serialises one report per episode round-robin.
// Ports: i_clk, i_rst_n (async active-low), i_block_sigs[N_MON], i_clear (sync clear),
//   o_report_valid/i_report_ready/o_report_idx (report handshake), o_deadlock_any (sticky),
//   o_report_ts (only when HLS_DEADLOCK_TS_EN is defined: cycle count at confirmation).
module hls_deadlock_report_ctrl
  import hls_deadlock_pkg::*;
#(
  parameter int N_MON = 4,
  parameter int THRESH = 16,
`ifdef HLS_DEADLOCK_TS_EN
  parameter int TS_W = TS_W_DEF,
`endif
  localparam int IDX_W = clog2_min1(N_MON)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_MON-1:0] i_block_sigs,
  input  logic             i_clear,
  output logic             o_report_valid,
  input  logic             i_report_ready,
  output logic [IDX_W-1:0] o_report_idx,
`ifdef HLS_DEADLOCK_TS_EN
  output logic [TS_W-1:0]  o_report_ts,
`endif
  output logic             o_deadlock_any
);
  state_t r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_j;
  logic [N_MON-1:0] w_pending;
  logic [N_MON-1:0] w_set;
  logic [N_MON-1:0] w_ack;
  logic w_hs;
  assign w_hs = (r_state == SEND) && i_report_ready;
  for (genvar g = 0; g < N_MON; g++) begin : g_ch
    assign w_ack[g] = w_hs && (o_report_idx == IDX_W'(g));
    hls_deadlock_persist_cnt #(.THRESH(THRESH)) u_cnt (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_block(i_block_sigs[g]),
      .i_ack(w_ack[g]),
      .i_clear(i_clear),
      .o_pending(w_pending[g]),
      .o_set(w_set[g])
    );
  end
  // scan downwards so the first pending bit at or after r_ptr is the last one written
  always_comb begin
    w_sel = '0;
    w_j = '0;
    for (int k = N_MON - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(r_ptr) + k) % N_MON);
      if (w_pending[w_j]) w_sel = w_j;
    end
  end
`ifdef HLS_DEADLOCK_TS_EN
  logic [TS_W-1:0] r_tsc;
  logic [TS_W-1:0] r_ts_reg [N_MON];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tsc <= '0;
      for (int i = 0; i < N_MON; i++) r_ts_reg[i] <= '0;
    end else begin
      r_tsc <= r_tsc + 1'b1;
      for (int i = 0; i < N_MON; i++) if (w_set[i]) r_ts_reg[i] <= r_tsc;
    end
  end
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      o_report_valid <= 1'b0;
      o_report_idx <= '0;
      o_deadlock_any <= 1'b0;
`ifdef HLS_DEADLOCK_TS_EN
      o_report_ts <= '0;
`endif
    end else if (i_clear) begin
      r_state <= IDLE;
      o_report_valid <= 1'b0;
      o_deadlock_any <= 1'b0;
    end else begin
      o_deadlock_any <= o_deadlock_any || (|w_set);
      if (r_state == IDLE) begin
        if (|w_pending) begin
          r_state <= SEND;
          o_report_valid <= 1'b1;
          o_report_idx <= w_sel;
`ifdef HLS_DEADLOCK_TS_EN
          o_report_ts <= r_ts_reg[w_sel];
`endif
        end
      end else if (i_report_ready) begin
        r_state <= IDLE;
        o_report_valid <= 1'b0;
        r_ptr <= (o_report_idx == IDX_W'(N_MON - 1)) ? '0 : o_report_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// tb_hls_deadlock_report_ctrl: scoreboard bench with a behavioural episode/arbitration model.
module tb_hls_deadlock_report_ctrl;
  localparam int N = 4;
  localparam int T = 8;
  localparam int TSM = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;
  logic rdy = 1'b0;
  logic [N-1:0] blk = '0;
  logic valid;
  logic dla;
  logic [1:0] idx;
`ifdef HLS_DEADLOCK_TS_EN
  logic [3:0] ts;
`endif
  always #5 clk = ~clk;

  hls_deadlock_report_ctrl #(
    .N_MON(N),
    .THRESH(T)
`ifdef HLS_DEADLOCK_TS_EN
    , .TS_W(4)
`endif
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_block_sigs(blk),
    .i_clear(clr),
    .o_report_valid(valid),
    .i_report_ready(rdy),
    .o_report_idx(idx),
`ifdef HLS_DEADLOCK_TS_EN
    .o_report_ts(ts),
`endif
    .o_deadlock_any(dla)
  );

  int errs = 0;
  int checks = 0;
  typedef struct {int idx; int ts;} rep_t;
  rep_t exp_q[$];
  int hs_log[$];

  // model: run = consecutive high samples, one confirmation per episode, round-robin grant
  int run[N];
  bit armed[N];
  bit pend[N];
  int tsr[N];
  bit busy;
  bit dla_m;
  int sel;
  int ptr;
  int tsc;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      run[i] = 0;
      armed[i] = 1;
      pend[i] = 0;
      tsr[i] = 0;
    end
    busy = 0;
    dla_m = 0;
    sel = 0;
    ptr = 0;
    tsc = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ns[N];
    int t0;
    bit any;
    t0 = tsc;
    tsc = (tsc + 1) % TSM;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        armed[i] = 1;
        pend[i] = 0;
      end
      busy = 0;
      dla_m = 0;
      exp_q.delete();
      return;
    end
    any = 0;
    for (int i = 0; i < N; i++) begin
      ns[i] = blk[i] && armed[i] && (run[i] + 1 == T);
      any |= pend[i];
    end
    if (!busy && any) begin
      for (int k = N - 1; k >= 0; k--) if (pend[(ptr + k) % N]) sel = (ptr + k) % N;
      busy = 1;
      exp_q.push_back('{sel, tsr[sel]});
    end else if (busy && rdy) begin
      busy = 0;
      pend[sel] = 0;
      ptr = (sel + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (ns[i]) begin
        pend[i] = 1;
        tsr[i] = t0;
        armed[i] = 0;
        dla_m = 1;
      end
      run[i] = blk[i] ? run[i] + 1 : 0;
      if (!blk[i]) armed[i] = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", int'(valid), int'(busy));
      check("deadlock_any", int'(dla), int'(dla_m));
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_report: got idx %0d expected none at %0t", idx, $time);
        end else begin
          check("report_idx", int'(idx), exp_q[0].idx);
`ifdef HLS_DEADLOCK_TS_EN
          check("report_ts", int'(ts), exp_q[0].ts);
`endif
          if (rdy && !clr) begin
            hs_log.push_back(exp_q[0].idx);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_dla", int'(dla), 0);
`ifdef HLS_DEADLOCK_TS_EN
    check("rst_ts", int'(ts), 0);
`endif
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] cur;
    #2;
    do_reset();
    // single held block reports once
    rdy = 1;
    blk = 4'b0100;
    tick(28);
    blk = 0;
    tick(3);
    check("s1_count", hs_log.size(), 1);
    if (hs_log.size() > 0) check("s1_idx", hs_log[0], 2);
    check("s1_dla", int'(dla), 1);
    clr = 1;
    tick(1);
    clr = 0;
    check("s1_clear_dla", int'(dla), 0);
    hs_log.delete();
    // seven-cycle pulse never confirms
    blk = 4'b0010;
    tick(7);
    blk = 0;
    tick(5);
    check("s2_count", hs_log.size(), 0);
    check("s2_dla", int'(dla), 0);
    // move ptr to 1, then three simultaneous confirmations under backpressure
    blk = 4'b0001;
    tick(8);
    blk = 0;
    tick(4);
    hs_log.delete();
    rdy = 0;
    blk = 4'b1011;
    tick(8);
    blk = 0;
    repeat (3) begin
      tick(6);
      rdy = 1;
      tick(1);
      rdy = 0;
    end
    tick(2);
    check("s3_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("s3_order0", hs_log[0], 1);
      check("s3_order1", hs_log[1], 3);
      check("s3_order2", hs_log[2], 0);
    end
    hs_log.delete();
    // second episode confirmed on the same edge as the first handshake
    blk = 4'b1000;
    tick(8);
    blk = 0;
    tick(1);
    blk = 4'b1000;
    tick(7);
    rdy = 1;
    tick(1);
    rdy = 0;
    blk = 0;
    tick(3);
    rdy = 1;
    tick(4);
    check("s4_count", hs_log.size(), 2);
    if (hs_log.size() == 2) check("s4_idx", hs_log[1], 3);
    hs_log.delete();
    // clear during SEND
    rdy = 0;
    blk = 4'b0100;
    tick(8);
    blk = 0;
    tick(2);
    check("s5_valid_pre", int'(valid), 1);
    clr = 1;
    tick(1);
    clr = 0;
    check("s5_valid_clr", int'(valid), 0);
    check("s5_dla_clr", int'(dla), 0);
    tick(3);
    check("s5_valid_after", int'(valid), 0);
    rdy = 1;
    blk = 4'b0100;
    tick(8);
    blk = 0;
    tick(4);
    check("s5_count", hs_log.size(), 1);
    // randomized traffic
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 8) == 0) cur[b] = ~cur[b];
      blk = cur;
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    blk = 0;
    clr = 0;
    rdy = 1;
    tick(10);
    check("drain_queue", exp_q.size(), 0);
    // reset while a report is presented
    rdy = 0;
    blk = 4'b0001;
    tick(8);
    blk = 0;
    tick(2);
    check("s6_valid_pre", int'(valid), 1);
    do_reset();
`ifdef HLS_DEADLOCK_TS_EN
    rdy = 1;
    tick(100);
    blk = 4'b0001;
    tick(8);
    blk = 0;
    tick(1);
    check("ts_valid", int'(valid), 1);
    check("ts_107", int'(ts), 107 % TSM);
    tick(3);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
